// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART receiver and the SoC IO decode.
// The slave modport is the receiver; the master modport is the SoC side.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  modport slave (
    input  rx,
    input  rx_pop,
    input  err_clr,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun
  );

  modport master (
    output rx,
    output rx_pop,
    output err_clr,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a small receive FIFO and
// sticky framing/overrun error flags.
module uart_rx #(
  parameter int unsigned CLK_MHZ    = 12,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     resetn,
  uart_rx_if.slave bus
);

  localparam int unsigned ClksPerBit = CLK_MHZ * 1000000 / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = PtrW + 1;

  localparam logic [CntW-1:0]   CntBitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]   CntHalfLast = CntW'(HalfBit - 1);
  localparam logic [CountW-1:0] CountFull   = CountW'(FIFO_DEPTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  // Two-flop synchroniser, preset to the idle line level.
  logic sync1_q, rx_s_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sr_q, sr_d;
  logic            push;
  logic            ferr_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfLast) begin
          cnt_d = '0;
          idx_d = 3'd0;
          // A line back high at mid start bit was a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == CntBitLast) begin
          cnt_d       = '0;
          sr_d[idx_q] = rx_s_q;
          idx_d       = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == CntBitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sr_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
    end
  end

  // Receive FIFO
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              full;
  logic              pop_eff;
  logic              push_ok;
  logic              ovr_set;

  always_comb begin
    full     = (count_q == CountFull);
    pop_eff  = bus.rx_pop && (count_q != '0);
    // A simultaneous pop frees the slot the push needs.
    push_ok  = push && (!full || pop_eff);
    ovr_set  = push && full && !pop_eff;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_eff ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_eff) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_eff) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= sr_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sticky error flags; a new event wins over a clear in the same cycle.
  logic frame_err_q, frame_err_d;
  logic overrun_q, overrun_d;

  always_comb begin
    frame_err_d = ferr_set | (frame_err_q & ~bus.err_clr);
    overrun_d   = ovr_set | (overrun_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data   = mem_q[rd_ptr_q];
  assign bus.rx_valid  = (count_q != '0);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitch, break, overrun, push/pop collision and mid-frame reset.
module tb_uart_rx;

  localparam int Cpb = 104;

  logic clk;
  logic resetn;
  uart_rx_if bus ();

  uart_rx #(
    .CLK_MHZ   (12),
    .BAUD      (115200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    bus.rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      tick(Cpb);
    end
    bus.rx = stop;
    tick(Cpb);
  endtask

  task automatic pop();
    bus.rx_pop = 1'b1;
    tick(1);
    bus.rx_pop = 1'b0;
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  int lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h7E, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_ferr: 1'b0};

    bus.rx      = 1'b1;
    bus.rx_pop  = 1'b0;
    bus.err_clr = 1'b0;
    resetn      = 1'b0;
    tick(3);
    chk("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("reset_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, bus.overrun}, 32'd0);
    resetn = 1'b1;
    tick(5);

    // Test 1: 0xA5 with latency measured from the start-bit fall.
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 1100; i++) begin
          tick(1);
          if (bus.rx_valid && lat < 0) lat = i;
        end
      end
    join
    chk("t1_latency_in_window", {31'd0, (lat >= 989 && lat <= 995)}, 32'd1);
    chk("t1_data", {24'd0, bus.rx_data}, 32'h0000_00A5);
    pop();
    chk("t1_valid_after_pop", {31'd0, bus.rx_valid}, 32'd0);

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop);
      if (!vecs[v].stop) begin
        tick(50);
        bus.rx = 1'b1;
      end
      tick(20);
      chk($sformatf("vec%0d_valid", v), {31'd0, bus.rx_valid}, {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid) begin
        chk($sformatf("vec%0d_data", v), {24'd0, bus.rx_data}, {24'd0, vecs[v].exp_data});
        pop();
      end
      chk($sformatf("vec%0d_ferr", v), {31'd0, bus.frame_err}, {31'd0, vecs[v].exp_ferr});
      clr_err();
    end

    // Test 2: start-bit glitch, then a good frame.
    bus.rx = 1'b0;
    tick(20);
    bus.rx = 1'b1;
    tick(200);
    chk("t2_glitch_no_byte", {31'd0, bus.rx_valid}, 32'd0);
    chk("t2_glitch_no_ferr", {31'd0, bus.frame_err}, 32'd0);
    send_frame(8'h3C, 1'b1);
    tick(20);
    chk("t2_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t2_data", {24'd0, bus.rx_data}, 32'h0000_003C);
    pop();

    // Test 3: low stop bit, line held low, then a good frame.
    send_frame(8'h7E, 1'b0);
    tick(300);
    chk("t3_break_no_byte", {31'd0, bus.rx_valid}, 32'd0);
    chk("t3_ferr_set", {31'd0, bus.frame_err}, 32'd1);
    bus.rx = 1'b1;
    tick(20);
    send_frame(8'h11, 1'b1);
    tick(20);
    chk("t3_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t3_data", {24'd0, bus.rx_data}, 32'h0000_0011);
    clr_err();
    chk("t3_ferr_cleared", {31'd0, bus.frame_err}, 32'd0);
    chk("t3_clr_keeps_fifo", {31'd0, bus.rx_valid}, 32'd1);
    pop();

    // Test 4: five back-to-back frames into a four-entry FIFO.
    for (int d = 1; d <= 5; d++) send_frame(8'(d), 1'b1);
    tick(5);
    chk("t4_overrun", {31'd0, bus.overrun}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t4_pop%0d_data", k), {24'd0, bus.rx_data}, k);
      pop();
    end
    chk("t4_empty", {31'd0, bus.rx_valid}, 32'd0);
    clr_err();
    chk("t4_overrun_cleared", {31'd0, bus.overrun}, 32'd0);

    // Test 5: pop lands on the same edge as the fifth push into a full FIFO.
    for (int d = 1; d <= 4; d++) send_frame(8'(d), 1'b1);
    fork
      send_frame(8'h05, 1'b1);
      begin
        tick(990);
        bus.rx_pop = 1'b1;
        tick(1);
        bus.rx_pop = 1'b0;
      end
    join
    tick(5);
    chk("t5_no_overrun", {31'd0, bus.overrun}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("t5_pop%0d_data", k), {24'd0, bus.rx_data}, k);
      pop();
    end
    chk("t5_empty", {31'd0, bus.rx_valid}, 32'd0);

    // Test 6: reset mid-frame with a byte queued and frame_err set.
    send_frame(8'h99, 1'b1);
    send_frame(8'h00, 1'b0);
    tick(30);
    bus.rx = 1'b1;
    tick(20);
    chk("t6_pre_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t6_pre_ferr", {31'd0, bus.frame_err}, 32'd1);
    fork
      send_frame(8'hF5, 1'b1);
      begin
        tick(5 * Cpb + 20);
        resetn = 1'b0;
        #2;
        chk("t6_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, bus.rx_data}, 32'd0);
        chk("t6_rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        chk("t6_rst_overrun", {31'd0, bus.overrun}, 32'd0);
        tick(10);
        resetn = 1'b1;
      end
    join
    tick(200);
    chk("t6_partial_discarded", {31'd0, bus.rx_valid}, 32'd0);
    send_frame(8'hC3, 1'b1);
    tick(20);
    chk("t6_next_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("t6_next_data", {24'd0, bus.rx_data}, 32'h0000_00C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
